// File: rtl/load_store_unit.sv
// Load/store unit: word-aligned bus access with strobes, load extraction, stall.
// Optional bus watchdog enabled by defining LSU_TIMEOUT_EN.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_cfg_check
        $error("load_store_unit: CNT_W too narrow for TIMEOUT_CYCLES");
    end

    logic [1:0]  state;
    logic [1:0]  lane_q;
    logic [2:0]  funct3_q;
    logic        write_q;
    logic        legal;
    logic        aligned;
    logic        timed_out;
    logic [3:0]  strb;
    logic [31:0] wdata_rep;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;

    assign req_ready = (state == S_IDLE);
    assign stall     = (req_ready & req_valid) | (state == S_BUS);

    always_comb begin
        legal = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = ~req_write;
            default:                legal = 1'b0;
        endcase
    end

    always_comb begin
        aligned   = 1'b1;
        strb      = 4'b0000;
        wdata_rep = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                strb      = 4'b0001 << req_addr[1:0];
                wdata_rep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                aligned   = ~req_addr[0];
                strb      = 4'b0011 << {req_addr[1], 1'b0};
                wdata_rep = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                aligned   = (req_addr[1:0] == 2'b00);
                strb      = 4'b1111;
            end
            default: begin
                aligned   = 1'b1;
                strb      = 4'b0000;
            end
        endcase
    end

    // Lane selection uses the address captured at acceptance.
    always_comb begin
        ld_byte = mem_rdata[7:0];
        case (lane_q)
            2'd0: ld_byte = mem_rdata[7:0];
            2'd1: ld_byte = mem_rdata[15:8];
            2'd2: ld_byte = mem_rdata[23:16];
            2'd3: ld_byte = mem_rdata[31:24];
            default: ld_byte = mem_rdata[7:0];
        endcase
        ld_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_data = {24'd0, ld_byte};
            3'b101:  load_data = {16'd0, ld_half};
            default: load_data = mem_rdata;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    logic [CNT_W-1:0] wait_cnt;

    // Limit is reached on the TIMEOUT_CYCLES-th unacknowledged BUS cycle.
    assign timed_out = ~mem_ack
                     & (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (state != S_BUS) begin
            wait_cnt <= '0;
        end else if (!mem_ack) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            lane_q    <= '0;
            funct3_q  <= '0;
            write_q   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wstrb <= '0;
            mem_wdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        lane_q    <= req_addr[1:0];
                        funct3_q  <= req_funct3;
                        write_q   <= req_write;
                        rsp_rdata <= '0;
                        if (legal && aligned) begin
                            state     <= S_BUS;
                            mem_req   <= 1'b1;
                            mem_we    <= req_write;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wstrb <= req_write ? strb : 4'b0000;
                            mem_wdata <= req_write ? wdata_rep : 32'd0;
                        end else begin
                            state     <= S_ERR;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end
                    end
                end
                S_BUS: begin
                    if (mem_ack) begin
                        state     <= S_RESP;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= write_q ? 32'd0 : load_data;
                    end else if (timed_out) begin
                        state     <= S_ERR;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end
                end
                S_RESP:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the core datapath and data memory.
- Takes one load/store request per instruction: byte/halfword/word, signed/unsigned.
- Generates word-aligned bus accesses with byte strobes and a request/acknowledge handshake that tolerates multi-cycle memory.
- Returns aligned, extended load data and drives a stall to the core while the access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles mem_req may wait for mem_ack (used only with LSU_TIMEOUT_EN)
- CNT_W, 5, width of the wait counter; must hold TIMEOUT_CYCLES

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous reset, active-low
- req_valid  in  1  core presents a memory instruction
- req_ready  out  1  unit can accept a request
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU; SB/SH/SW)
- req_addr  in  32  byte address (ALU result)
- req_wdata  in  32  store data (rs2)
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  extended load data; 0 for stores/errors
- rsp_err  out  1  misaligned/illegal/timeout, valid with rsp_valid
- stall  out  1  core must hold PC and pipeline state
- mem_req  out  1  bus access request
- mem_we  out  1  bus write enable
- mem_addr  out  32  word address, {req_addr[31:2],2'b00}
- mem_wstrb  out  4  byte write strobes
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  memory completes the access this cycle
- mem_rdata  in  32  read word, valid when mem_ack=1

Behaviour:
- Reset (reset=0 at an edge) forces IDLE and zeros all registered outputs. mem_req, rsp_valid, rsp_err and stall are 0 the cycle after. An in-flight access is abandoned with no response. Reset dominates everything else.
- FSM states: IDLE, BUS, RESP, ERR.
- IDLE:
  - req_ready=1; accepts when req_valid=1.
  - Captures addr, funct3, write, wdata into registers.
  - Legal and aligned -> BUS.
  - Otherwise -> ERR, with no bus access.
- Legality:
  - Loads: funct3 in {000, 001, 010, 100, 101}.
  - Stores: funct3 in {000, 001, 010}.
  - Alignment: halfword needs addr[0]=0; word needs addr[1:0]=00.
  - Byte accesses are always aligned.
- BUS:
  - mem_req=1.
  - mem_addr, mem_we, mem_wstrb and mem_wdata held stable until mem_ack=1 is sampled.
  - Then -> RESP; load data is registered from mem_rdata in that cycle.
- Strobes:
  - SB: 4'b0001<<addr[1:0].
  - SH: 4'b0011<<{addr[1],1'b0}.
  - SW: 4'b1111.
  - Loads: 4'b0000.
- wdata:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata.
- Load extract: lane = addr[1:0] (byte) or addr[1] (half).
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: full word.
- RESP: rsp_valid=1 and rsp_err=0 for exactly one cycle, then -> IDLE. rsp_rdata = extracted data for loads, 0 for stores.
- ERR: rsp_valid=1, rsp_err=1, rsp_rdata=0 for one cycle, then -> IDLE.
- req_ready=0 in BUS, RESP and ERR. A new request is accepted only in IDLE, giving at most one access per 3 cycles.
- stall = (IDLE & req_valid) | BUS. Stall is combinational and 0 in RESP/ERR, so the core advances on the rsp_valid cycle.
- Latency: with acceptance at cycle T and zero-wait memory (mem_ack at T+1), rsp_valid is at T+2. Each wait cycle adds one. Error responses arrive at T+1.
- mem_ack outside BUS is ignored. mem_rdata is sampled only when mem_ack=1 in BUS.
- All outputs except stall and req_ready are registered.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined:
  - CNT_W-bit counter clears on entry to BUS and increments each BUS cycle with mem_ack=0.
  - When the count reaches TIMEOUT_CYCLES with no ack, mem_req drops and the FSM goes to ERR (rsp_err=1).
  - An ack in the same cycle the limit is reached wins: normal RESP.
- Undefined: no counter exists; BUS waits indefinitely for mem_ack.

Test Plan:
- Reset: reset=0 mid-BUS, then release -> next cycle mem_req=0, rsp_valid=0, stall=0, req_ready=1; no response for the abandoned access.
- LW at addr 0x10, mem_ack at T+1, mem_rdata=0xDEADBEEF -> mem_addr=0x10, mem_wstrb=0000, rsp_valid at T+2, rsp_rdata=0xDEADBEEF, stall high only in cycles T and T+1.
- LB at addr 0x13, mem_rdata=0x80FF7F01 -> rsp_rdata=0xFFFFFF80. LBU at the same address -> 0x00000080. LH at 0x12 -> 0xFFFF80FF.
- SB at 0x21 with wdata=0x000000AB, mem_ack delayed 3 cycles -> mem_wstrb=0010, mem_wdata=0xABABABAB, mem_addr=0x20, outputs stable through the wait, rsp_valid at T+5 with rsp_rdata=0. SH at 0x22 -> wstrb=1100.
- Misaligned LW at 0x06 -> no mem_req; rsp_valid=1, rsp_err=1 at T+1. Store with funct3=101 -> same error response.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=16, mem_ack held 0 -> mem_req drops after 16 BUS cycles, rsp_err=1. Ack arriving on cycle 16 -> normal response.
